instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Read-side initiator for the instruction memory. Holds the PC, drives the memory address and captures the returned
//  instruction word. Presents the word to the decoder over a valid/ready handshake and handles branch redirects.
//  Sits between the instruction memory and the decode stage. Sustains 1 instruction/cycle when not stalled.
// PARAMETERS
//  ADDR_WIDTH   8      PC / memory address width
//  DATA_WIDTH   8      instruction word width
//  RESET_PC     0      PC value loaded on reset
//  HALT_OPCODE  8'hFF  opcode that stops fetch (used only with IFU_HALT_DETECT_EN)
// PORTS
//  clock            in   1           system clock
//  reset_n          in   1           asynchronous, active-low reset
//  fetch_en         in   1           1 = fetch allowed; 0 = freeze PC and capture
//  mem_address      out  ADDR_WIDTH  address to instruction memory (= pc register, combinational)
//  mem_data         in   DATA_WIDTH  word from instruction memory; memory samples address on negedge
//  instr_out        out  DATA_WIDTH  registered instruction to decoder
//  instr_pc         out  ADDR_WIDTH  address instr_out was fetched from
//  instr_valid      out  1           instr_out/instr_pc valid
//  instr_ready      in   1           decoder accepts word this cycle
//  redirect_valid   in   1           branch/jump taken; load redirect_target
//  redirect_target  in   ADDR_WIDTH  new PC
//  halted           out  1           fetch stopped on HALT_OPCODE
// BEHAVIOUR
//  - Single clock, asynchronous active-low reset (reset_n). All state changes on posedge clock.
//  - Reset values: pc=RESET_PC, state=START, instr_out=0, instr_pc=0, instr_valid=0, halted=0.
//  - Memory timing: mem_address changes only at posedge, is read at following negedge, and mem_data is captured at the
//    next posedge. Fetch latency = 1 cycle from PC update to capture.
//  - FSM states:
//      START: one bubble cycle after reset. Memory settles on pc, no capture. Next state is RUN.
//      RUN:   normal fetch/capture.
//      HALT:  fetch stopped (only reachable with IFU_HALT_DETECT_EN).
//  - RUN capture condition: fetch_en && (!instr_valid || instr_ready). When it holds:
//      instr_out<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
//  - Accept without a new capture (e.g. fetch_en=0): instr_valid<=0.
//  - Stall (instr_valid && !instr_ready): instr_out, instr_pc, instr_valid and pc all held.
//    mem_address stays stable, so mem_data is still correct when the stall releases.
//  - PC arithmetic is modulo 2^ADDR_WIDTH: 8'hFF + 1 = 8'h00. No error flag is raised.
//  - Redirect has top priority in every state except reset. On redirect_valid:
//      pc<=redirect_target, instr_valid<=0 (pending word discarded even if unaccepted), halted<=0, state<=RUN.
//    First redirected word is valid 1 cycle later (1 bubble).
//  - Simultaneous redirect_valid and instr_ready: the handshake completes on the old word, then the flush applies.
//  - fetch_en=0: pc and capture frozen. instr_valid is still cleared by instr_ready.
//  - Reset mid-stall or mid-redirect: immediate return to reset values. Any pending word is lost.
// CONFIGURATION
//  IFU_HALT_DETECT_EN defined:
//   - A captured word equal to HALT_OPCODE is presented normally (valid, pc+1 recorded), then state<=HALT, halted<=1.
//   - In HALT, pc is frozen and no further captures occur. Leave HALT only via redirect_valid or reset.
//  IFU_HALT_DETECT_EN undefined:
//   - HALT_OPCODE is an ordinary word. The HALT state is absent and halted is tied to 0.
// TESTING
//  1 Reset, memory 0..3 = A0,A1,A2,A3, instr_ready=1
//    -> 1 bubble (START), then instr_out A0,A1,A2,A3 on consecutive cycles with instr_pc 0,1,2,3.
//  2 instr_ready=0 for 3 cycles while instr_out=A1
//    -> instr_out, instr_pc=1 and mem_address=2 held. A2 appears 1 cycle after ready returns; no skip, no duplicate.
//  3 redirect_valid with target 8'h40 while stalled on A1
//    -> A1 dropped, instr_valid=0 for 1 cycle, then instr_pc=0x40 with word mem[0x40].
//  4 Run from pc=8'hFE
//    -> instr_pc sequence FE, FF, 00, 01 (wrap).
//  5 Assert reset_n=0 asynchronously mid-cycle during a stall
//    -> instr_valid=0 and mem_address=RESET_PC immediately, without waiting for a clock edge.
//  6 IFU_HALT_DETECT_EN, mem[2]=FF
//    -> FF delivered with instr_pc=2, then halted=1 and no further valid words.
//    -> redirect to 0 clears halted and resumes at 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Read-side initiator for the instruction memory. Holds the PC,
//                drives the memory address, captures the returned word and
//                presents it to decode over a valid/ready handshake. Handles
//                branch redirects and sustains one instruction per cycle.
//  Options     : IFU_HALT_DETECT_EN - when defined, a captured HALT_OPCODE is
//                delivered and then fetch stops until redirect or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int unsigned              ADDR_WIDTH  = 8,
    parameter int unsigned              DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [DATA_WIDTH-1:0]    HALT_OPCODE = 8'hFF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    fetch_en,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic [DATA_WIDTH-1:0]   instr_out,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_target,
    output logic                    halted
);

    // State encoding: START is the single post-reset bubble where the memory
    // settles on the reset PC before the first capture.
    localparam logic [1:0] c_st_start = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
`ifdef IFU_HALT_DETECT_EN
    localparam logic [1:0] c_st_halt  = 2'd2;
`endif

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic [DATA_WIDTH-1:0]  r_instr_out;
    logic [DATA_WIDTH-1:0]  w_instr_out_next;
    logic [ADDR_WIDTH-1:0]  r_instr_pc;
    logic [ADDR_WIDTH-1:0]  w_instr_pc_next;
    logic                   r_instr_valid;
    logic                   w_instr_valid_next;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_halt_hit;

    // A new word may be captured only in RUN and only when the output slot is
    // empty or being emptied this cycle.
    assign w_capture = (r_state == c_st_run) && fetch_en
                       && (!r_instr_valid || instr_ready);
    assign w_accept  = r_instr_valid && instr_ready;

`ifdef IFU_HALT_DETECT_EN
    assign w_halt_hit = w_capture && (mem_data == HALT_OPCODE);
`else
    assign w_halt_hit = 1'b0;
    logic [DATA_WIDTH-1:0]  w_unused_halt_opcode;
    assign w_unused_halt_opcode = HALT_OPCODE;
`endif

    // The memory reads whatever the PC register holds; it only moves at posedge.
    assign mem_address = r_pc;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_start;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: redirect wins from any state and always resumes RUN.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = c_st_run;
        end else begin
            case (r_state)
                c_st_start: w_state_next = c_st_run;
`ifdef IFU_HALT_DETECT_EN
                c_st_run:   if (w_halt_hit) w_state_next = c_st_halt;
`endif
                default:    w_state_next = r_state;
            endcase
        end
    end

    // Output/datapath next values. A redirect discards any pending word; the
    // handshake on that word still completes from the decoder's point of view.
    always_comb begin
        w_pc_next          = r_pc;
        w_instr_out_next   = r_instr_out;
        w_instr_pc_next    = r_instr_pc;
        w_instr_valid_next = r_instr_valid;
        if (redirect_valid) begin
            w_pc_next          = redirect_target;
            w_instr_valid_next = 1'b0;
        end else if (w_capture) begin
            w_instr_out_next   = mem_data;
            w_instr_pc_next    = r_pc;
            w_instr_valid_next = 1'b1;
            w_pc_next          = r_pc + 1'b1;   // wraps modulo 2^ADDR_WIDTH
        end else if (w_accept) begin
            w_instr_valid_next = 1'b0;
        end
    end

    // Datapath registers; a stall simply holds every one of them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_instr_out   <= w_instr_out_next;
            r_instr_pc    <= w_instr_pc_next;
            r_instr_valid <= w_instr_valid_next;
        end
    end

`ifdef IFU_HALT_DETECT_EN
    logic r_halted;

    // Halt flag rises with the capture of the halt word and clears on redirect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_halt_hit) begin
            r_halted <= 1'b1;
        end
    end

    assign halted = r_halted;
`else
    assign halted = w_halt_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Self-checking bench for instruction_fetch_unit: directed
//                vector table, hand-written corner sequences and randomized
//                traffic against a behavioural model. Define
//                IFU_HALT_DETECT_EN to exercise the halt option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

`ifdef IFU_HALT_DETECT_EN
    localparam bit c_halt_en = 1'b1;
`else
    localparam bit c_halt_en = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       fetch_en = 1'b0;
    logic       instr_ready = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_target = 8'h00;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       halted;

    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_errors = 0;

    // Behavioural model state
    bit         m_run;
    bit         m_valid;
    bit         m_halt;
    logic [7:0] m_pc;
    logic [7:0] m_out;
    logic [7:0] m_ipc;

    typedef struct {
        logic       fe;
        logic       rdy;
        logic       rv;
        logic [7:0] tgt;
        logic       ev;
        logic [7:0] eout;
        logic [7:0] epc;
        logic [7:0] eaddr;
    } vec_t;

    vec_t tbl [20];

    always #5 clock = ~clock;

    // Instruction memory: samples the address on the falling edge.
    always @(negedge clock) mem_data <= mem[mem_address];

    instruction_fetch_unit #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .RESET_PC    (8'h00),
        .HALT_OPCODE (8'hFF)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_en        (fetch_en),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_valid = 0; m_halt = 0;
        m_pc = 8'h00; m_out = 8'h00; m_ipc = 8'h00;
    endtask

    // One clock of the fetch rules: redirect first, then the bubble, then
    // capture of the word stored at the PC, else a plain accept.
    task automatic model_step(input bit fe, input bit rdy, input bit rv, input logic [7:0] tgt);
        if (rv) begin
            m_pc = tgt; m_valid = 0; m_halt = 0; m_run = 1;
        end else if (!m_run) begin
            m_run = 1;
        end else if (!m_halt && fe && (!m_valid || rdy)) begin
            m_out = mem[m_pc]; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 8'd1;
            if (c_halt_en && m_out == 8'hFF) m_halt = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_model();
        check("valid", {31'd0, instr_valid}, {31'd0, m_valid});
        check("out",   {24'd0, instr_out},   {24'd0, m_out});
        check("pc",    {24'd0, instr_pc},    {24'd0, m_ipc});
        check("addr",  {24'd0, mem_address}, {24'd0, m_pc});
        check("halted",{31'd0, halted},      {31'd0, m_halt});
    endtask

    // Called at posedge+1: drive inputs, advance model and DUT one cycle.
    task automatic tick(input bit fe, input bit rdy, input bit rv, input logic [7:0] tgt);
        fetch_en = fe; instr_ready = rdy; redirect_valid = rv; redirect_target = tgt;
        model_step(fe, rdy, rv, tgt);
        @(posedge clock);
        #1;
        compare_model();
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        fetch_en = 0; instr_ready = 0; redirect_valid = 0; redirect_target = 8'h00;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // ---------------- reset values ----------------
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h33;
        for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
        mem[8'h40] = 8'h5A; mem[8'h41] = 8'h5B;
        mem[8'hFE] = 8'hC0; mem[8'hFF] = 8'hC1;
        #1;
        assert_reset();
        #2;
        check("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check("rst_out",    {24'd0, instr_out},   32'd0);
        check("rst_pc",     {24'd0, instr_pc},    32'd0);
        check("rst_addr",   {24'd0, mem_address}, 32'd0);
        check("rst_halted", {31'd0, halted},      32'd0);

        // ---------------- directed table ----------------
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA0, 8'h00, 8'h01};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA1, 8'h01, 8'h02};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA1, 8'h01, 8'h02};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA1, 8'h01, 8'h02};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA1, 8'h01, 8'h02};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA2, 8'h02, 8'h03};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA3, 8'h03, 8'h04};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA4, 8'h04, 8'h05};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA4, 8'h04, 8'h05};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 8'hA4, 8'h04, 8'h40};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h40, 8'h41};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h5A, 8'h40, 8'h41};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h5A, 8'h40, 8'h41};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5B, 8'h41, 8'h42};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h5B, 8'h41, 8'hFE};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC0, 8'hFE, 8'hFF};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC1, 8'hFF, 8'h00};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA0, 8'h00, 8'h01};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA1, 8'h01, 8'h02};

        release_reset();
        for (int i = 0; i < 20; i++) begin
            fetch_en = tbl[i].fe; instr_ready = tbl[i].rdy;
            redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
            @(posedge clock);
            #1;
            check($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].ev});
            check($sformatf("tbl%0d_out", i),   {24'd0, instr_out},   {24'd0, tbl[i].eout});
            check($sformatf("tbl%0d_pc", i),    {24'd0, instr_pc},    {24'd0, tbl[i].epc});
            check($sformatf("tbl%0d_addr", i),  {24'd0, mem_address}, {24'd0, tbl[i].eaddr});
            check($sformatf("tbl%0d_halted", i),{31'd0, halted},      32'd0);
        end

        // ---------------- async reset during a stall ----------------
        assert_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        release_reset();
        tick(1, 1, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        tick(1, 0, 0, 8'h00);
        check("stall_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_valid", {31'd0, instr_valid}, 32'd0);
        check("areset_addr",  {24'd0, mem_address}, 32'd0);
        check("areset_out",   {24'd0, instr_out},   32'd0);
        assert_reset();

        // ---------------- halt opcode sequence ----------------
        for (int i = 0; i < 256; i++) mem[i] = 8'h10 + 8'(i);
        mem[2] = 8'hFF;
        release_reset();
        tick(1, 1, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        check("halt_word", {24'd0, instr_out}, 32'h0000_00FF);
        check("halt_pc",   {24'd0, instr_pc},  32'd2);
`ifdef IFU_HALT_DETECT_EN
        check("halt_flag", {31'd0, halted},    32'd1);
`endif
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 8'h00);
`ifdef IFU_HALT_DETECT_EN
            check("halt_novalid", {31'd0, instr_valid}, 32'd0);
            check("halt_addr",    {24'd0, mem_address}, 32'd3);
`else
            check("nohalt_valid", {31'd0, instr_valid}, 32'd1);
`endif
        end
        tick(1, 1, 1, 8'h00);
        check("redir_halted", {31'd0, halted},      32'd0);
        check("redir_valid",  {31'd0, instr_valid}, 32'd0);
        tick(1, 1, 0, 8'h00);
        check("resume_word", {24'd0, instr_out}, 32'h0000_0010);
        check("resume_pc",   {24'd0, instr_pc},  32'd0);

        // ---------------- randomized traffic ----------------
        assert_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        release_reset();
        for (int n = 0; n < 1500; n++) begin
            tick(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 10) == 0,
                 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
